// File: rtl/button_cmd_sched_pkg.sv
// rtl/button_cmd_sched_pkg.sv - shared constants for the button command scheduler
package button_cmd_sched_pkg;

    localparam int NUM_BTN_DEFAULT = 5;

    localparam logic [1:0] RPT_REL   = 2'd0;
    localparam logic [1:0] RPT_DELAY = 2'd1;
    localparam logic [1:0] RPT_RPT   = 2'd2;

    localparam logic SCH_IDLE  = 1'b0;
    localparam logic SCH_OFFER = 1'b1;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

endpackage

// File: rtl/button_repeat.sv
// rtl/button_repeat.sv - per-button press edge detection and hold auto-repeat event generator
module button_repeat
    import button_cmd_sched_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    localparam logic [31:0] DELAY_LAST = (REPEAT_DELAY == 0) ? 32'd0 : 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_LAST  = (REPEAT_RATE == 0) ? 32'd0 : 32'(REPEAT_RATE - 1);
    localparam logic        REPEAT_EN  = (REPEAT_DELAY != 0);

    logic        btn_q;
    logic        armed;
    logic        press;
    logic        delay_hit;
    logic        rate_hit;
    logic [1:0]  state;
    logic [31:0] cnt;

    // armed stays low for the first edge after reset so a held button is not seen as a press
    assign press     = armed & btn & ~btn_q;
    assign delay_hit = btn & (state == RPT_DELAY) & (cnt == DELAY_LAST);
    assign rate_hit  = btn & REPEAT_EN & (state == RPT_RPT) & (cnt == RATE_LAST);
    assign evt       = press | delay_hit | rate_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b0;
            armed <= 1'b0;
            state <= RPT_REL;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            armed <= 1'b1;
            if (!btn) begin
                state <= RPT_REL;
                cnt   <= '0;
            end else begin
                case (state)
                    RPT_REL: begin
                        if (press) begin
                            state <= REPEAT_EN ? RPT_DELAY : RPT_RPT;
                            cnt   <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (delay_hit) begin
                            state <= RPT_RPT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    RPT_RPT: begin
                        if (!REPEAT_EN || rate_hit) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: begin
                        state <= RPT_REL;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_cmd_sched.sv
// rtl/button_cmd_sched.sv - button events to pending/overrun flags and a round-robin command offer
module button_cmd_sched
    import button_cmd_sched_pkg::*;
#(
    parameter int          NUM_BTN      = NUM_BTN_DEFAULT,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_db,
    input  logic               cmd_ready,
    input  logic               ovr_clr,
    output logic               cmd_valid,
    output logic [2:0]         cmd_id,
    output logic [NUM_BTN-1:0] overrun
);

    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] grant_vec;
    logic [NUM_BTN-1:0] ovr_set;
    logic               state;
    logic [2:0]         last_grant;
    logic [2:0]         pick_idx;
    logic               pick_found;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_repeat (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_db[i]),
            .evt   (evt[i])
        );
    end

    assign cmd_valid = (state == SCH_OFFER);

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            grant_vec[i] = cmd_valid & cmd_ready & (cmd_id == 3'(i));
        end
    end

    // an event landing on the bit being granted this edge re-arms pending instead of overrunning
    assign ovr_set = evt & pending & ~grant_vec;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int j = 1; j <= NUM_BTN; j++) begin
            if (!pick_found && pending[(int'(last_grant) + j) % NUM_BTN]) begin
                pick_found = 1'b1;
                pick_idx   = 3'((int'(last_grant) + j) % NUM_BTN);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= evt | (pending & ~grant_vec);
            overrun <= (overrun & ~{NUM_BTN{ovr_clr}}) | ovr_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCH_IDLE;
            cmd_id     <= '0;
            last_grant <= 3'(NUM_BTN - 1);
        end else begin
            case (state)
                SCH_IDLE: begin
                    if (pick_found) begin
                        cmd_id     <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= SCH_OFFER;
                    end
                end
                default: begin
                    if (cmd_ready) begin
                        state <= SCH_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_cmd_sched.sv
// tb/tb_button_cmd_sched.sv - directed and randomized checks against a hold-time reference model
`timescale 1ns/1ps
module tb_button_cmd_sched;
    import button_cmd_sched_pkg::*;

    localparam int NB = 5;
    localparam int RD = 8;
    localparam int RR = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          cmd_ready = 1'b0;
    logic          ovr_clr   = 1'b0;
    logic [NB-1:0] btn_db    = '0;
    logic          cmd_valid;
    logic [2:0]    cmd_id;
    logic [NB-1:0] overrun;
    logic          nr_valid;
    logic [2:0]    nr_id;
    logic [NB-1:0] nr_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    button_cmd_sched #(.NUM_BTN(NB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_db    (btn_db),
        .cmd_ready (cmd_ready),
        .ovr_clr   (ovr_clr),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .overrun   (overrun)
    );

    button_cmd_sched #(.NUM_BTN(NB), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut_nr (
        .clk       (clk),
        .reset     (reset),
        .btn_db    (btn_db),
        .cmd_ready (cmd_ready),
        .ovr_clr   (ovr_clr),
        .cmd_valid (nr_valid),
        .cmd_id    (nr_id),
        .overrun   (nr_overrun)
    );

    // Reference model: each button tracks how long it has been held since a genuine press;
    // events occur at hold 0 and at RD, RD+RR, RD+2RR, ...
    int          m_hold [NB];
    bit          m_prev [NB];
    bit          m_armed;
    bit          m_valid;
    bit [NB-1:0] m_pend;
    bit [NB-1:0] m_ovr;
    int          m_id;
    int          m_last;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_hold[i] = -1;
            m_prev[i] = 1'b0;
        end
        m_armed = 1'b0;
        m_valid = 1'b0;
        m_pend  = '0;
        m_ovr   = '0;
        m_id    = 0;
        m_last  = NB - 1;
    endtask

    task automatic model_edge();
        bit [NB-1:0] ev;
        bit [NB-1:0] old_pend;
        bit          granted;
        if (reset) begin
            model_reset();
            return;
        end
        ev = '0;
        for (int i = 0; i < NB; i++) begin
            if (!btn_db[i]) begin
                m_hold[i] = -1;
            end else if (m_armed && !m_prev[i]) begin
                m_hold[i] = 0;
                ev[i] = 1'b1;
            end else if (m_hold[i] >= 0) begin
                m_hold[i]++;
                if (m_hold[i] >= RD && (m_hold[i] - RD) % RR == 0) ev[i] = 1'b1;
            end
            m_prev[i] = btn_db[i];
        end
        m_armed  = 1'b1;
        old_pend = m_pend;
        for (int i = 0; i < NB; i++) begin
            granted = m_valid && cmd_ready && (m_id == i);
            if (ev[i] && old_pend[i] && !granted) m_ovr[i] = 1'b1;
            else if (ovr_clr) m_ovr[i] = 1'b0;
            m_pend[i] = ev[i] | (old_pend[i] & !granted);
        end
        if (m_valid) begin
            if (cmd_ready) m_valid = 1'b0;
        end else if (old_pend != '0) begin
            for (int k = 1; k <= NB; k++) begin
                if (old_pend[(m_last + k) % NB]) begin
                    m_id    = (m_last + k) % NB;
                    m_last  = m_id;
                    m_valid = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int seen;
        btn_db = '1;
        reset  = 1'b1;
        model_reset();
        tick();
        tick();
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cmd_valid); else n_pass++;
        n_checks++; if (cmd_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", cmd_id); else n_pass++;
        n_checks++; if (overrun !== '0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_checks++; if (nr_valid !== 1'b0) $display("FAIL reset_nr_valid: got %b want 0", nr_valid); else n_pass++;
        reset = 1'b0;
        seen  = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (cmd_valid) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL reset_held_no_cmd: got %0d commands want 0", seen); else n_pass++;
        btn_db = '0;
        tick();
        tick();
    endtask

    task automatic test_single_tap();
        int cnt, first, bad_id;
        cnt = 0; first = -1; bad_id = 0;
        cmd_ready = 1'b1;
        btn_db[BTN_L] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) btn_db[BTN_L] = 1'b0;
            tick();
            if (cmd_valid) begin
                cnt++;
                if (first < 0) first = c;
                if (cmd_id !== 3'(BTN_L)) bad_id++;
            end
        end
        n_checks++; if (cnt != 1) $display("FAIL tap_count: got %0d want 1", cnt); else n_pass++;
        n_checks++; if (first != 1) $display("FAIL tap_latency: got %0d want 1", first); else n_pass++;
        n_checks++; if (bad_id != 0) $display("FAIL tap_id: got %0d wrong ids want 0", bad_id); else n_pass++;
    endtask

    task automatic test_hold();
        int got [$];
        int exp_c [4];
        int bad_id;
        exp_c = '{1, 9, 13, 17};
        bad_id = 0;
        cmd_ready = 1'b1;
        btn_db[BTN_C] = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c == 20) btn_db[BTN_C] = 1'b0;
            tick();
            if (cmd_valid) begin
                got.push_back(c);
                if (cmd_id !== 3'(BTN_C)) bad_id++;
            end
        end
        n_checks++; if (got.size() != 4) $display("FAIL hold_count: got %0d want 4", got.size()); else n_pass++;
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            n_checks++;
            if (got[k] != exp_c[k]) $display("FAIL hold_time%0d: got cycle %0d want %0d", k, got[k], exp_c[k]);
            else n_pass++;
        end
        n_checks++; if (bad_id != 0) $display("FAIL hold_id: got %0d wrong ids want 0", bad_id); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int ids [$];
        int cyc [$];
        int exp_id [3];
        int exp_cy [3];
        exp_id = '{BTN_C, BTN_L, BTN_D};
        exp_cy = '{1, 3, 5};
        do_reset();
        cmd_ready = 1'b1;
        btn_db = 5'b10101;
        for (int c = 0; c < 10; c++) begin
            tick();
            btn_db = '0;
            if (cmd_valid) begin
                ids.push_back(int'(cmd_id));
                cyc.push_back(c);
            end
        end
        n_checks++; if (ids.size() != 3) $display("FAIL simul_count: got %0d want 3", ids.size()); else n_pass++;
        for (int k = 0; k < 3 && k < ids.size(); k++) begin
            n_checks++;
            if (ids[k] != exp_id[k] || cyc[k] != exp_cy[k])
                $display("FAIL simul_cmd%0d: got id %0d at %0d want id %0d at %0d", k, ids[k], cyc[k], exp_id[k], exp_cy[k]);
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        int hs;
        cmd_ready = 1'b0;
        btn_db[BTN_R] = 1'b1; tick();
        btn_db[BTN_R] = 1'b0; tick();
        btn_db[BTN_R] = 1'b1; tick();
        btn_db[BTN_R] = 1'b0; tick();
        tick();
        n_checks++; if (cmd_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", cmd_valid); else n_pass++;
        n_checks++; if (cmd_id !== 3'(BTN_R)) $display("FAIL ovr_id: got %0d want 3", cmd_id); else n_pass++;
        n_checks++; if (overrun !== 5'b01000) $display("FAIL ovr_flag: got %b want 01000", overrun); else n_pass++;
        cmd_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 8; c++) begin
            if (cmd_valid && cmd_ready) hs++;
            tick();
        end
        n_checks++; if (hs != 1) $display("FAIL ovr_drain: got %0d commands want 1", hs); else n_pass++;
        n_checks++; if (overrun !== 5'b01000) $display("FAIL ovr_sticky: got %b want 01000", overrun); else n_pass++;
        ovr_clr = 1'b1; tick();
        ovr_clr = 1'b0;
        n_checks++; if (overrun !== '0) $display("FAIL ovr_clear: got %b want 0", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid_offer();
        int seen, wait_c;
        cmd_ready = 1'b0;
        btn_db[BTN_U] = 1'b1;
        wait_c = 0;
        while (!cmd_valid && wait_c < 6) begin
            tick();
            wait_c++;
        end
        n_checks++; if (cmd_valid !== 1'b1) $display("FAIL rmo_offer: got %b want 1 within 6 cycles", cmd_valid); else n_pass++;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rmo_async_drop: got %b want 0", cmd_valid); else n_pass++;
        tick();
        reset = 1'b0;
        cmd_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cmd_valid) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL rmo_held_silent: got %0d commands want 0", seen); else n_pass++;
        btn_db[BTN_U] = 1'b0; tick();
        btn_db[BTN_U] = 1'b1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (cmd_valid && cmd_id === 3'(BTN_U)) seen++;
        end
        n_checks++; if (seen != 1) $display("FAIL rmo_repress: got %0d commands want 1", seen); else n_pass++;
        btn_db = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5, 0) == 0) btn_db[$urandom_range(NB - 1, 0)] ^= 1'b1;
            cmd_ready = ($urandom_range(3, 0) != 0);
            ovr_clr   = ($urandom_range(15, 0) == 0);
            reset     = ($urandom_range(599, 0) == 0);
            tick();
            reset = 1'b0;
            n_checks++;
            if (cmd_valid !== m_valid || overrun !== m_ovr || (m_valid && cmd_id !== 3'(m_id))) begin
                $display("FAIL rand_cycle %0d: got v=%b id=%0d ovr=%b want v=%b id=%0d ovr=%b",
                         c, cmd_valid, cmd_id, overrun, m_valid, m_id, m_ovr);
                errs++;
            end else begin
                n_pass++;
            end
        end
        btn_db = '0; ovr_clr = 1'b0; cmd_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_no_repeat();
        int cnt, bad_id;
        cnt = 0; bad_id = 0;
        do_reset();
        cmd_ready = 1'b1;
        btn_db[BTN_D] = 1'b1;
        for (int c = 0; c < 106; c++) begin
            if (c == 100) btn_db[BTN_D] = 1'b0;
            tick();
            if (nr_valid) begin
                cnt++;
                if (nr_id !== 3'(BTN_D)) bad_id++;
            end
        end
        n_checks++; if (cnt != 1) $display("FAIL norpt_count: got %0d want 1", cnt); else n_pass++;
        n_checks++; if (bad_id != 0) $display("FAIL norpt_id: got %0d wrong ids want 0", bad_id); else n_pass++;
        n_checks++; if (nr_overrun !== '0) $display("FAIL norpt_overrun: got %b want 0", nr_overrun); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_tap();
        test_hold();
        test_simultaneous();
        test_overrun();
        test_reset_mid_offer();
        test_random();
        test_no_repeat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
